// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - packet-atomic round-robin arbiter sharing one sync_fifo write port
module fifo_wr_arbiter #(
    parameter int Width  = 16,
    parameter int NumReq = 4,
    parameter int IdW    = $clog2(NumReq)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NumReq-1:0]       req_valid,
    input  logic [NumReq*Width-1:0] req_data,
    input  logic [NumReq-1:0]       req_last,
    output logic [NumReq-1:0]       req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_w_enb,
    output logic [Width-1:0]        fifo_din,
    output logic                    grant_valid,
    output logic [IdW-1:0]          grant_id
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state, state_nxt;
    logic [IdW-1:0] owner, owner_nxt;
    logic [IdW-1:0] rr_ptr, rr_ptr_nxt;
    logic [IdW-1:0] pick, idx, wrap_ptr;
    logic [IdW:0]   sum;
    logic           found, beat;

    // Search starts at rr_ptr; the modular reduction keeps indices below NumReq
    // even when NumReq is not a power of two.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NumReq; k++) begin
            sum = {1'b0, rr_ptr} + (IdW+1)'(k);
            if (sum >= (IdW+1)'(NumReq)) begin
                sum = sum - (IdW+1)'(NumReq);
            end
            idx = sum[IdW-1:0];
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign wrap_ptr = (owner == IdW'(NumReq - 1)) ? '0 : owner + 1'b1;

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        rr_ptr_nxt  = rr_ptr;
        req_ready   = '0;
        beat        = (state == GRANT) && req_valid[owner] && !fifo_full;
        fifo_w_enb  = beat;
        fifo_din    = beat ? req_data[int'(owner)*Width +: Width] : '0;
        grant_valid = (state == GRANT);
        grant_id    = owner;
        case (state)
            IDLE: begin
                if (found) begin
                    owner_nxt = pick;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                req_ready[owner] = !fifo_full;
                if (beat && req_last[owner]) begin
                    rr_ptr_nxt = wrap_ptr;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

endmodule
